t05_huffman_decode: RTL and testbench

- Huffman bitstream decoder. The inverse of the team's serial translation encoder.
- Consumes a serial bitstream made of a 32-bit MSB-first total-character count followed by concatenated codeword bits. It walks a Huffman tree held in an external node table and emits one decoded 8-bit character per codeword.
- Sits between the bitstream source (SPI/SRAM reader) and the character sink (file writer).

---
 rtl/t05_huffman_pkg.sv | 10 +
 rtl/t05_huffman_decode.sv | 88 ++++++++
 tb/tb_t05_huffman_decode.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/t05_huffman_pkg.sv
// t05_huffman_pkg: shared states and node-word field positions for the Huffman decoder
package t05_huffman_pkg;
  typedef enum logic [2:0] {HEADER, FETCH, WALK, EMIT, DONE, ERROR} state_t;
  localparam int LEAF_BIT  = 15;
  localparam int CHAR_LSB  = 0;
  localparam int LEFT_LSB  = 7;
  localparam int RIGHT_LSB = 0;
  localparam int CHILD_W   = 7;
  localparam int HDR_BITS  = 32;
endpackage

// File: rtl/t05_huffman_decode.sv
// t05_huffman_decode: serial Huffman bitstream decoder walking an external node table
module t05_huffman_decode
  import t05_huffman_pkg::*;
#(
  parameter int NODE_AW   = 7,
  parameter int ROOT_IDX  = 0,
  parameter int MAX_DEPTH = 127
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bitIn,
  input  logic               bitValid,
  output logic               bitReady,
  output logic               nodeReq,
  output logic [NODE_AW-1:0] nodeAddr,
  input  logic               nodeAck,
  input  logic [15:0]        nodeData,
  output logic [7:0]         charOut,
  output logic               charValid,
  input  logic               charReady,
  output logic [31:0]        totChar,
  output logic               done,
  output logic               err
);
  state_t             state_q;
  logic [4:0]         hcnt_q;
  logic [31:0]        tot_q, tot_d, emit_q, emit_d;
  logic [6:0]         depth_q;
  logic [NODE_AW-1:0] ptr_q, child_d;
  logic [13:0]        node_q;
  logic               unused_node;
  // bit 14 of the node word carries no meaning for this decoder
  assign unused_node = nodeData[14];
  assign tot_d     = {tot_q[30:0], bitIn};
  assign emit_d    = emit_q + 32'd1;
  assign child_d   = NODE_AW'(bitIn ? node_q[RIGHT_LSB +: CHILD_W] : node_q[LEFT_LSB +: CHILD_W]);
  assign bitReady  = state_q == HEADER || state_q == WALK;
  assign nodeReq   = state_q == FETCH;
  assign nodeAddr  = ptr_q;
  assign charValid = state_q == EMIT;
  assign charOut   = charValid ? node_q[CHAR_LSB +: 8] : 8'd0;
  assign totChar   = tot_q;
  assign done      = state_q == DONE;
  assign err       = state_q == ERROR;
  // header capture, node fetch, bit-driven tree walk and character hand-off in one FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HEADER;
      hcnt_q  <= '0;
      tot_q   <= '0;
      emit_q  <= '0;
      depth_q <= '0;
      ptr_q   <= NODE_AW'(ROOT_IDX);
      node_q  <= '0;
    end else begin
      case (state_q)
        HEADER: if (bitValid) begin
          tot_q  <= tot_d;
          hcnt_q <= hcnt_q + 5'd1;
          if (hcnt_q == 5'(HDR_BITS - 1)) begin
            state_q <= tot_d == 32'd0 ? DONE : FETCH;
            ptr_q   <= NODE_AW'(ROOT_IDX);
          end
        end
        FETCH: if (nodeAck) begin
          node_q  <= nodeData[13:0];
          state_q <= nodeData[LEAF_BIT] ? EMIT : WALK;
        end
        WALK: if (bitValid) begin
          if (depth_q == 7'(MAX_DEPTH)) begin
            state_q <= ERROR;
          end else begin
            depth_q <= depth_q + 7'd1;
            ptr_q   <= child_d;
            state_q <= FETCH;
          end
        end
        EMIT: if (charReady) begin
          emit_q  <= emit_d;
          depth_q <= '0;
          ptr_q   <= NODE_AW'(ROOT_IDX);
          state_q <= emit_d == tot_q ? DONE : FETCH;
        end
        default: state_q <= state_q;
      endcase
    end
  end
endmodule

// File: tb/tb_t05_huffman_decode.sv
// tb_t05_huffman_decode: directed scenarios for the Huffman decoder with a modelled node table, bit source and sink
module tb_t05_huffman_decode;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bitIn, bitValid, bitReady, nodeReq, nodeAck, charValid, charReady, done, err;
  logic [6:0]  nodeAddr;
  logic [15:0] nodeData;
  logic [7:0]  charOut;
  logic [31:0] totChar;

  int   checks = 0, failures = 0;
  logic [15:0] mem [0:127];
  logic bq [$];
  logic [7:0] got [$];
  bit   toggle_en = 0, sink_rdy = 1, phase = 0;
  int   ack_dly = 0, wcnt = 0, cyc = 0;
  int   done_cyc = -1, xfer_cyc = -1, bit_cyc = -1, req_cycles = 0, cv_cycles = 0;

  t05_huffman_decode dut (
    .clk(clk), .rst(rst), .bitIn(bitIn), .bitValid(bitValid), .bitReady(bitReady),
    .nodeReq(nodeReq), .nodeAddr(nodeAddr), .nodeAck(nodeAck), .nodeData(nodeData),
    .charOut(charOut), .charValid(charValid), .charReady(charReady),
    .totChar(totChar), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // environment: bit source, node-table responder and character sink, all driven on the falling edge
  initial begin
    bitIn = 0; bitValid = 0; nodeAck = 0; nodeData = 16'hFFFF; charReady = 0;
    forever begin
      @(negedge clk);
      cyc++;
      phase = ~phase;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (nodeReq) req_cycles++;
      if (charValid) cv_cycles++;
      charReady = sink_rdy;
      if (charValid && charReady) begin
        got.push_back(charOut);
        xfer_cyc = cyc;
      end
      bitValid = !rst && bq.size() > 0 && (!toggle_en || phase);
      bitIn = bq.size() > 0 ? bq[0] : 1'b0;
      if (bitValid && bitReady) begin
        void'(bq.pop_front());
        bit_cyc = cyc;
      end
      if (nodeReq && wcnt == ack_dly) begin
        nodeAck = 1; nodeData = mem[nodeAddr]; wcnt = 0;
      end else begin
        nodeAck = 0; nodeData = 16'hFFFF; wcnt = nodeReq ? wcnt + 1 : 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1;
    bq.delete(); got.delete();
    toggle_en = 0; ack_dly = 0; sink_rdy = 1;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 0;
    done_cyc = -1; xfer_cyc = -1; bit_cyc = -1; req_cycles = 0; cv_cycles = 0;
  endtask

  task automatic push_word(input logic [31:0] n);
    for (int i = 31; i >= 0; i--) bq.push_back(n[i]);
  endtask

  task automatic load_ab();
    mem[0] = 16'h0082;
    mem[1] = 16'h8041;
    mem[2] = 16'h8042;
  endtask

  task automatic wait_end(input int lim, output bit to);
    for (int i = 0; i < lim && !(done || err); i++) @(negedge clk);
    @(negedge clk);
    to = !(done || err);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (nodeReq !== 1'b0) begin failures++; $display("FAIL reset_nodeReq got=%0b exp=0", nodeReq); end
    checks++; if (nodeAddr !== 7'd0) begin failures++; $display("FAIL reset_nodeAddr got=%0h exp=0", nodeAddr); end
    checks++; if (charValid !== 1'b0 || charOut !== 8'd0) begin failures++; $display("FAIL reset_char got=%0b/%0h exp=0/0", charValid, charOut); end
    checks++; if (totChar !== 32'd0) begin failures++; $display("FAIL reset_totChar got=%0h exp=0", totChar); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", done, err); end
    checks++; if (bitReady !== 1'b1) begin failures++; $display("FAIL reset_bitReady got=%0b exp=1", bitReady); end
  endtask

  task automatic test_basic();
    bit to;
    logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h41};
    do_reset(); load_ab();
    push_word(32'd3); bq.push_back(0); bq.push_back(1); bq.push_back(0);
    wait_end(500, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=%0b exp=0", to); end
    checks++; if (got.size() !== 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) if (i < got.size()) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL basic_char%0d got=%0h exp=%0h", i, got[i], exp[i]); end
    end
    checks++; if (totChar !== 32'd3) begin failures++; $display("FAIL basic_totChar got=%0d exp=3", totChar); end
    checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL basic_flags got=%0b%0b exp=10", done, err); end
    checks++; if (done_cyc !== xfer_cyc + 1) begin failures++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, xfer_cyc + 1); end
  endtask

  task automatic test_zero();
    bit to;
    do_reset(); load_ab();
    push_word(32'd0);
    wait_end(200, to);
    checks++; if (to || done !== 1'b1) begin failures++; $display("FAIL zero_done got=%0b exp=1", done); end
    checks++; if (done_cyc !== bit_cyc + 1) begin failures++; $display("FAIL zero_done_timing got=%0d exp=%0d", done_cyc, bit_cyc + 1); end
    checks++; if (req_cycles !== 0) begin failures++; $display("FAIL zero_nodeReq got=%0d exp=0", req_cycles); end
    checks++; if (cv_cycles !== 0) begin failures++; $display("FAIL zero_charValid got=%0d exp=0", cv_cycles); end
    checks++; if (bitReady !== 1'b0) begin failures++; $display("FAIL zero_bitReady got=%0b exp=0", bitReady); end
  endtask

  task automatic test_root_leaf();
    bit to;
    do_reset();
    mem[0] = 16'h805A;
    push_word(32'd4); bq.push_back(1); bq.push_back(0); bq.push_back(1);
    wait_end(300, to);
    checks++; if (to || done !== 1'b1) begin failures++; $display("FAIL leaf_done got=%0b exp=1", done); end
    checks++; if (got.size() !== 4) begin failures++; $display("FAIL leaf_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 8'h5A) begin failures++; $display("FAIL leaf_char%0d got=%0h exp=5a", i, got[i]); end
    end
    checks++; if (bq.size() !== 3) begin failures++; $display("FAIL leaf_bits_left got=%0d exp=3", bq.size()); end
    checks++; if (bitReady !== 1'b0) begin failures++; $display("FAIL leaf_bitReady got=%0b exp=0", bitReady); end
  endtask

  task automatic test_stall();
    bit to;
    logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h41};
    do_reset(); load_ab();
    sink_rdy = 0;
    push_word(32'd3); bq.push_back(0); bq.push_back(1); bq.push_back(0);
    for (int i = 0; i < 200 && !charValid; i++) @(negedge clk);
    checks++; if (charValid !== 1'b1) begin failures++; $display("FAIL stall_first_char got=%0b exp=1", charValid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (charValid !== 1'b1 || charOut !== 8'h41 || nodeReq !== 1'b0 || bitReady !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d got=v%0b c%0h r%0b b%0b exp=v1 c41 r0 b0", i, charValid, charOut, nodeReq, bitReady);
      end
    end
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL stall_no_xfer got=%0d exp=0", got.size()); end
    sink_rdy = 1;
    wait_end(300, to);
    checks++; if (to || got.size() !== 3) begin failures++; $display("FAIL stall_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) if (i < got.size()) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL stall_char%0d got=%0h exp=%0h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_toggle();
    bit to;
    int bad = 0;
    logic prev_req = 0;
    logic [6:0] prev_addr = '0;
    logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h41};
    do_reset(); load_ab();
    toggle_en = 1; ack_dly = 3;
    push_word(32'd3); bq.push_back(0); bq.push_back(1); bq.push_back(0);
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (nodeReq && prev_req && nodeAddr !== prev_addr) bad++;
      prev_req = nodeReq; prev_addr = nodeAddr;
    end
    wait_end(10, to);
    checks++; if (to || done !== 1'b1) begin failures++; $display("FAIL toggle_done got=%0b exp=1", done); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL toggle_addr_stable got=%0d exp=0", bad); end
    checks++; if (req_cycles !== 24) begin failures++; $display("FAIL toggle_req_cycles got=%0d exp=24", req_cycles); end
    checks++; if (cv_cycles !== 3) begin failures++; $display("FAIL toggle_cv_cycles got=%0d exp=3", cv_cycles); end
    checks++; if (got.size() !== 3) begin failures++; $display("FAIL toggle_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) if (i < got.size()) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL toggle_char%0d got=%0h exp=%0h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_error();
    bit to;
    do_reset();
    mem[0] = 16'h0000;
    push_word(32'd1);
    for (int i = 0; i < 130; i++) bq.push_back(0);
    wait_end(1000, to);
    checks++; if (to || err !== 1'b1) begin failures++; $display("FAIL error_err got=%0b exp=1", err); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL error_done got=%0b exp=0", done); end
    checks++; if (bq.size() !== 2) begin failures++; $display("FAIL error_bits_left got=%0d exp=2", bq.size()); end
    repeat (3) @(negedge clk);
    checks++; if (bitReady !== 1'b0 || nodeReq !== 1'b0) begin failures++; $display("FAIL error_quiet got=b%0b r%0b exp=b0 r0", bitReady, nodeReq); end
    checks++; if (err !== 1'b1 || got.size() !== 0) begin failures++; $display("FAIL error_sticky got=%0b/%0d exp=1/0", err, got.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset(); load_ab();
    push_word(32'd3); bq.push_back(0); bq.push_back(1); bq.push_back(0);
    for (int i = 0; i < 300 && !(got.size() == 1 && nodeReq); i++) @(negedge clk);
    checks++; if (!(got.size() == 1 && nodeReq)) begin failures++; $display("FAIL rmid_reach got=%0d exp=1", got.size()); end
    rst = 1;
    #1;
    checks++; if (nodeReq !== 1'b0 || nodeAddr !== 7'd0) begin failures++; $display("FAIL rmid_node got=%0b/%0h exp=0/0", nodeReq, nodeAddr); end
    checks++; if (charValid !== 1'b0 || charOut !== 8'd0) begin failures++; $display("FAIL rmid_char got=%0b/%0h exp=0/0", charValid, charOut); end
    checks++; if (totChar !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rmid_state got=%0h/%0b%0b exp=0/00", totChar, done, err); end
    bq.delete(); got.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    push_word(32'd2); bq.push_back(1); bq.push_back(0);
    wait_end(500, to);
    checks++; if (to || done !== 1'b1 || totChar !== 32'd2) begin failures++; $display("FAIL rmid_redo got=%0b/%0d exp=1/2", done, totChar); end
    checks++; if (got.size() !== 2) begin failures++; $display("FAIL rmid_count got=%0d exp=2", got.size()); end
    if (got.size() == 2) begin
      checks++; if (got[0] !== 8'h42 || got[1] !== 8'h41) begin failures++; $display("FAIL rmid_chars got=%0h,%0h exp=42,41", got[0], got[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_root_leaf();
    test_stall();
    test_toggle();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
